// File: rtl/load_buffer_if.sv
// Signal bundle between the load buffer and its neighbours: address unit, ROB,
// memory controller and common data bus. Names follow the load buffer's view.
interface load_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned ID_W   = 6
);
  logic              addrunit_lbuffer_en_in;
  logic [ADDR_W-1:0] addrunit_lbuffer_a_in;
  logic [ROB_W-1:0]  addrunit_lbuffer_dest_in;
  logic [ID_W-1:0]   addrunit_lbuffer_opcode_in;
  logic              lbuffer_full_out;
  logic [ROB_W-1:0]  lbuffer_rob_h_out;
  logic              rob_lbuffer_safe_in;
  logic              rob_lbuffer_rst_in;
  logic              lbuffer_mem_en_out;
  logic [ADDR_W-1:0] lbuffer_mem_a_out;
  logic [1:0]        lbuffer_mem_size_out;
  logic              mem_lbuffer_valid_in;
  logic [ADDR_W-1:0] mem_lbuffer_data_in;
  logic              lbuffer_cdb_en_out;
  logic [ROB_W-1:0]  lbuffer_cdb_dest_out;
  logic [ADDR_W-1:0] lbuffer_cdb_value_out;

  // Load buffer side.
  modport slave (
    input  addrunit_lbuffer_en_in, addrunit_lbuffer_a_in, addrunit_lbuffer_dest_in,
    input  addrunit_lbuffer_opcode_in, rob_lbuffer_safe_in, rob_lbuffer_rst_in,
    input  mem_lbuffer_valid_in, mem_lbuffer_data_in,
    output lbuffer_full_out, lbuffer_rob_h_out, lbuffer_mem_en_out, lbuffer_mem_a_out,
    output lbuffer_mem_size_out, lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
    output lbuffer_cdb_value_out
  );

  // Environment side (address unit, ROB, memory controller, CDB).
  modport master (
    output addrunit_lbuffer_en_in, addrunit_lbuffer_a_in, addrunit_lbuffer_dest_in,
    output addrunit_lbuffer_opcode_in, rob_lbuffer_safe_in, rob_lbuffer_rst_in,
    output mem_lbuffer_valid_in, mem_lbuffer_data_in,
    input  lbuffer_full_out, lbuffer_rob_h_out, lbuffer_mem_en_out, lbuffer_mem_a_out,
    input  lbuffer_mem_size_out, lbuffer_cdb_en_out, lbuffer_cdb_dest_out,
    input  lbuffer_cdb_value_out
  );
endinterface

// File: rtl/load_buffer.sv
// In-order load queue: accepts address-unit loads, issues the head to memory once
// the ROB marks it safe, extends the returned data and broadcasts it on the CDB.
module load_buffer #(
  parameter int unsigned    ADDR_W    = 32,
  parameter int unsigned    ROB_W     = 4,
  parameter int unsigned    ID_W      = 6,
  parameter int unsigned    DEPTH_LOG = 3,
  parameter logic [ID_W-1:0] OpLb     = ID_W'(11),
  parameter logic [ID_W-1:0] OpLh     = ID_W'(12),
  parameter logic [ID_W-1:0] OpLw     = ID_W'(13),
  parameter logic [ID_W-1:0] OpLbu    = ID_W'(14),
  parameter logic [ID_W-1:0] OpLhu    = ID_W'(15)
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  load_buffer_if.slave bus
);
  localparam int unsigned Depth = 1 << DEPTH_LOG;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e               state_q, state_d;
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [ADDR_W-1:0]    addr_mem [Depth];
  logic [ROB_W-1:0]     dest_mem [Depth];
  logic [ID_W-1:0]      op_mem   [Depth];
  logic                 mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 cdb_en_q, cdb_en_d;
  logic [ROB_W-1:0]     cdb_dest_q, cdb_dest_d;
  logic [ADDR_W-1:0]    cdb_value_q, cdb_value_d;
  logic                 full, enq, deq, flush, valid;

  function automatic logic [1:0] size_of(logic [ID_W-1:0] op);
    if (op == OpLb || op == OpLbu) return 2'd0;
    if (op == OpLh || op == OpLhu) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [ADDR_W-1:0] extend(logic [ID_W-1:0] op, logic [ADDR_W-1:0] d);
    if (op == OpLb)  return {{(ADDR_W-8){d[7]}}, d[7:0]};
    if (op == OpLbu) return {{(ADDR_W-8){1'b0}}, d[7:0]};
    if (op == OpLh)  return {{(ADDR_W-16){d[15]}}, d[15:0]};
    if (op == OpLhu) return {{(ADDR_W-16){1'b0}}, d[15:0]};
    if (op == OpLw)  return d;
    return '0;
  endfunction

  assign flush = bus.rob_lbuffer_rst_in;
  assign valid = bus.mem_lbuffer_valid_in;
  assign full  = (count_q == (DEPTH_LOG+1)'(Depth));

  assign bus.lbuffer_full_out      = full;
  // Head tag reads as zero while empty so the output is clean after reset.
  assign bus.lbuffer_rob_h_out     = (count_q != '0) ? dest_mem[head_q] : '0;
  assign bus.lbuffer_mem_en_out    = mem_en_q;
  assign bus.lbuffer_mem_a_out     = mem_a_q;
  assign bus.lbuffer_mem_size_out  = mem_size_q;
  assign bus.lbuffer_cdb_en_out    = cdb_en_q;
  assign bus.lbuffer_cdb_dest_out  = cdb_dest_q;
  assign bus.lbuffer_cdb_value_out = cdb_value_q;

  // Next-state: issue/complete FSM, queue pointers; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_en_d    = mem_en_q;
    mem_a_d     = mem_a_q;
    mem_size_d  = mem_size_q;
    cdb_en_d    = 1'b0;
    cdb_dest_d  = cdb_dest_q;
    cdb_value_d = cdb_value_q;
    enq         = 1'b0;
    deq         = 1'b0;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      mem_en_d = 1'b0;
      case (state_q)
        StWait:  state_d = valid ? StIdle : StDrain;
        StDrain: state_d = valid ? StIdle : StDrain;
        default: state_d = StIdle;
      endcase
    end else begin
      enq = bus.addrunit_lbuffer_en_in && !full;
      case (state_q)
        StIdle: begin
          if (count_q != '0 && bus.rob_lbuffer_safe_in) begin
            state_d    = StWait;
            mem_en_d   = 1'b1;
            mem_a_d    = addr_mem[head_q];
            mem_size_d = size_of(op_mem[head_q]);
          end
        end
        StWait: begin
          if (valid) begin
            state_d     = StIdle;
            mem_en_d    = 1'b0;
            cdb_en_d    = 1'b1;
            cdb_dest_d  = dest_mem[head_q];
            cdb_value_d = extend(op_mem[head_q], bus.mem_lbuffer_data_in);
            deq         = 1'b1;
          end
        end
        StDrain: begin
          // Response to the flushed request is swallowed here.
          if (valid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      tail_d  = tail_q + DEPTH_LOG'(enq);
      head_d  = head_q + DEPTH_LOG'(deq);
      count_d = count_q + (DEPTH_LOG+1)'(enq) - (DEPTH_LOG+1)'(deq);
    end
  end

  // State registers: synchronous active-low reset, frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_size_q  <= '0;
      cdb_en_q    <= 1'b0;
      cdb_dest_q  <= '0;
      cdb_value_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_a_q     <= mem_a_d;
      mem_size_q  <= mem_size_d;
      cdb_en_q    <= cdb_en_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // Queue storage: written at the tail on an accepted enqueue.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && enq) begin
      addr_mem[tail_q] <= bus.addrunit_lbuffer_a_in;
      dest_mem[tail_q] <= bus.addrunit_lbuffer_dest_in;
      op_mem[tail_q]   <= bus.addrunit_lbuffer_opcode_in;
    end
  end
endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer: stimulus queues expected memory requests and
// CDB results; a memory responder and a CDB monitor pop and compare them.
module tb_load_buffer;
  localparam logic [5:0] OpLb = 6'd11, OpLh = 6'd12, OpLw = 6'd13, OpLbu = 6'd14,
                         OpLhu = 6'd15;

  typedef struct {logic [3:0] dest; logic [31:0] value;} cdb_t;
  typedef struct {logic [31:0] addr; logic [1:0] size; logic [31:0] data; int delay;} mem_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  cdb_t cdb_q[$];
  mem_t mem_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   auto_mem = 1'b1;
  bit   mem_busy = 1'b0;

  always #5 clk = ~clk;

  load_buffer_if #(.ADDR_W(32), .ROB_W(4), .ID_W(6)) bus ();

  load_buffer #(.ADDR_W(32), .ROB_W(4), .ID_W(6), .DEPTH_LOG(3)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic enq(logic [31:0] a, logic [3:0] d, logic [5:0] op);
    bus.addrunit_lbuffer_en_in     = 1'b1;
    bus.addrunit_lbuffer_a_in      = a;
    bus.addrunit_lbuffer_dest_in   = d;
    bus.addrunit_lbuffer_opcode_in = op;
    @(negedge clk);
    bus.addrunit_lbuffer_en_in = 1'b0;
  endtask

  task automatic expect_mem(logic [31:0] a, logic [1:0] sz, logic [31:0] data, int dly);
    mem_q.push_back('{addr: a, size: sz, data: data, delay: dly});
  endtask

  task automatic expect_cdb(logic [3:0] d, logic [31:0] v);
    cdb_q.push_back('{dest: d, value: v});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((cdb_q.size() != 0 || mem_q.size() != 0 || mem_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 300), 32'd1);
    tick(2);
  endtask

  task automatic wait_mem_en(string name);
    int n = 0;
    while (!bus.lbuffer_mem_en_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.lbuffer_mem_en_out), 32'd1);
  endtask

  // CDB monitor: every broadcast must match the oldest expected result.
  always @(negedge clk) begin
    cdb_t e;
    if (bus.lbuffer_cdb_en_out) begin
      if (cdb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cdb_unexpected: got dest %h value %h, want no broadcast",
                 bus.lbuffer_cdb_dest_out, bus.lbuffer_cdb_value_out);
      end else begin
        e = cdb_q.pop_front();
        check("cdb_dest", 32'(bus.lbuffer_cdb_dest_out), 32'(e.dest));
        check("cdb_value", bus.lbuffer_cdb_value_out, e.value);
      end
    end
  end

  // Memory responder: checks each new request, answers after its programmed delay.
  initial begin
    mem_t m;
    forever begin
      @(negedge clk);
      if (auto_mem && bus.lbuffer_mem_en_out) begin
        mem_busy = 1'b1;
        if (mem_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mem_unexpected: got request addr %h, want none",
                   bus.lbuffer_mem_a_out);
          m = '{addr: 32'h0, size: 2'd0, data: 32'h0, delay: 1};
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", bus.lbuffer_mem_a_out, m.addr);
          check("mem_size", 32'(bus.lbuffer_mem_size_out), 32'(m.size));
        end
        repeat (m.delay - 1) @(negedge clk);
        bus.mem_lbuffer_valid_in = 1'b1;
        bus.mem_lbuffer_data_in  = m.data;
        @(negedge clk);
        bus.mem_lbuffer_valid_in = 1'b0;
        bus.mem_lbuffer_data_in  = 32'h0;
        mem_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addrunit_lbuffer_en_in     = 1'b0;
    bus.addrunit_lbuffer_a_in      = 32'h0;
    bus.addrunit_lbuffer_dest_in   = 4'h0;
    bus.addrunit_lbuffer_opcode_in = 6'h0;
    bus.rob_lbuffer_safe_in        = 1'b0;
    bus.rob_lbuffer_rst_in         = 1'b0;
    bus.mem_lbuffer_valid_in       = 1'b0;
    bus.mem_lbuffer_data_in        = 32'h0;

    // Reset state.
    tick(3);
    check("rst_full", 32'(bus.lbuffer_full_out), 32'd0);
    check("rst_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd0);
    check("rst_cdb_en", 32'(bus.lbuffer_cdb_en_out), 32'd0);
    check("rst_rob_h", 32'(bus.lbuffer_rob_h_out), 32'd0);
    rst = 1'b1;

    // Single LW, memory answers two cycles after the request.
    bus.rob_lbuffer_safe_in = 1'b1;
    expect_mem(32'h100, 2'd2, 32'h12345678, 2);
    expect_cdb(4'd3, 32'h12345678);
    enq(32'h100, 4'd3, OpLw);
    wait_done();
    check("lw_idle_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd0);

    // Extension rules.
    expect_mem(32'h201, 2'd0, 32'h000000F0, 1); expect_cdb(4'd1, 32'hFFFFFFF0);
    expect_mem(32'h202, 2'd0, 32'h000000F0, 2); expect_cdb(4'd2, 32'h000000F0);
    expect_mem(32'h204, 2'd1, 32'h00008001, 3); expect_cdb(4'd3, 32'hFFFF8001);
    expect_mem(32'h206, 2'd1, 32'h00008001, 1); expect_cdb(4'd4, 32'h00008001);
    enq(32'h201, 4'd1, OpLb);
    enq(32'h202, 4'd2, OpLbu);
    enq(32'h204, 4'd3, OpLh);
    enq(32'h206, 4'd4, OpLhu);
    wait_done();

    // Fill to eight (pointers wrap), ninth ignored, then drain in order.
    bus.rob_lbuffer_safe_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_mem(32'h300 + 32'(4 * i), 2'd2, 32'hA0000000 + 32'(i), (i % 2 == 0) ? 1 : 3);
      expect_cdb(4'(8 + i), 32'hA0000000 + 32'(i));
      enq(32'h300 + 32'(4 * i), 4'(8 + i), OpLw);
    end
    check("fill_full", 32'(bus.lbuffer_full_out), 32'd1);
    check("fill_head", 32'(bus.lbuffer_rob_h_out), 32'd8);
    enq(32'h3FC, 4'd0, OpLw);
    check("ninth_full", 32'(bus.lbuffer_full_out), 32'd1);
    check("ninth_head", 32'(bus.lbuffer_rob_h_out), 32'd8);
    bus.rob_lbuffer_safe_in = 1'b1;
    wait_done();
    check("drained_full", 32'(bus.lbuffer_full_out), 32'd0);

    // Head held back by safe=0.
    bus.rob_lbuffer_safe_in = 1'b0;
    enq(32'h400, 4'd5, OpLhu);
    for (int i = 0; i < 5; i++) begin
      check("hold_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd0);
      check("hold_rob_h", 32'(bus.lbuffer_rob_h_out), 32'd5);
      tick();
    end
    expect_mem(32'h400, 2'd1, 32'h0000ABCD, 2);
    expect_cdb(4'd5, 32'h0000ABCD);
    bus.rob_lbuffer_safe_in = 1'b1;
    tick();
    check("release_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd1);
    wait_done();

    // Flush in WAIT; stale response lands 3 cycles later; load enqueued in DRAIN.
    expect_mem(32'h500, 2'd2, 32'hDEADBEEF, 4);
    enq(32'h500, 4'd6, OpLw);
    wait_mem_en("flush_issue");
    bus.rob_lbuffer_rst_in = 1'b1;
    tick();
    bus.rob_lbuffer_rst_in = 1'b0;
    check("flush_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd0);
    expect_mem(32'h600, 2'd1, 32'h0001FFFE, 1);
    expect_cdb(4'd7, 32'hFFFFFFFE);
    enq(32'h600, 4'd7, OpLh);
    check("drain_no_issue0", 32'(bus.lbuffer_mem_en_out), 32'd0);
    check("drain_head", 32'(bus.lbuffer_rob_h_out), 32'd7);
    tick();
    check("drain_no_issue1", 32'(bus.lbuffer_mem_en_out), 32'd0);
    wait_done();

    // rdy low mid-WAIT freezes everything, even a flush; then reset mid-WAIT.
    auto_mem = 1'b0;
    enq(32'h700, 4'd9, OpLw);
    wait_mem_en("freeze_issue");
    rdy = 1'b0;
    bus.rob_lbuffer_rst_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("freeze_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd1);
      check("freeze_mem_a", bus.lbuffer_mem_a_out, 32'h700);
      check("freeze_size", 32'(bus.lbuffer_mem_size_out), 32'd2);
      check("freeze_cdb_en", 32'(bus.lbuffer_cdb_en_out), 32'd0);
      check("freeze_rob_h", 32'(bus.lbuffer_rob_h_out), 32'd9);
    end
    rdy = 1'b1;
    bus.rob_lbuffer_rst_in = 1'b0;
    rst = 1'b0;
    tick();
    check("mrst_mem_en", 32'(bus.lbuffer_mem_en_out), 32'd0);
    check("mrst_mem_a", bus.lbuffer_mem_a_out, 32'h0);
    check("mrst_size", 32'(bus.lbuffer_mem_size_out), 32'd0);
    check("mrst_cdb_dest", 32'(bus.lbuffer_cdb_dest_out), 32'd0);
    check("mrst_cdb_value", bus.lbuffer_cdb_value_out, 32'h0);
    check("mrst_full", 32'(bus.lbuffer_full_out), 32'd0);
    check("mrst_rob_h", 32'(bus.lbuffer_rob_h_out), 32'd0);
    rst = 1'b1;
    auto_mem = 1'b1;

    // Back in IDLE: a fresh load completes normally.
    expect_mem(32'h800, 2'd0, 32'h12345680, 2);
    expect_cdb(4'hA, 32'h00000080);
    enq(32'h800, 4'hA, OpLbu);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- Receiving end of the address-unit → load-buffer path.
- Queues computed load requests (address, ROB tag, opcode) in program order.
- Issues them one at a time to the memory controller once the ROB declares the head load safe.
- Sign/zero-extends the returned data and broadcasts the result to the CDB/ROB.
- Sits between the address unit, the ROB, the memory controller and the common data bus.

Parameters:
ADDR_W, 32, address/data width (`AddressWidth)
ROB_W, 4, ROB tag width (`ROBWidth)
ID_W, 6, opcode width (`IDWidth); opcode values `LB/`LH/`LW/`LBU/`LHU from constant.vh
DEPTH_LOG, 3, log2 of queue depth (8 entries)

Ports:
clk_in  in  1  clock, all state on rising edge
rst_in  in  1  reset, synchronous, active-low
rdy_in  in  1  global ready; low freezes all state
addrunit_lbuffer_en_in  in  1  enqueue request
addrunit_lbuffer_a_in  in  ADDR_W  effective address
addrunit_lbuffer_dest_in  in  ROB_W  destination ROB tag
addrunit_lbuffer_opcode_in  in  ID_W  load opcode
lbuffer_full_out  out  1  queue full, stalls issue upstream
lbuffer_rob_h_out  out  ROB_W  tag of head entry (valid when nonempty)
rob_lbuffer_safe_in  in  1  ROB: head load has no older conflicting store
rob_lbuffer_rst_in  in  1  misprediction flush
lbuffer_mem_en_out  out  1  memory read request
lbuffer_mem_a_out  out  ADDR_W  read address
lbuffer_mem_size_out  out  2  0=byte, 1=half, 2=word
mem_lbuffer_valid_in  in  1  read data valid (one-cycle pulse)
mem_lbuffer_data_in  in  ADDR_W  read data, LSB-aligned
lbuffer_cdb_en_out  out  1  result broadcast strobe
lbuffer_cdb_dest_out  out  ROB_W  result tag
lbuffer_cdb_value_out  out  ADDR_W  extended result

Behaviour:
- Reset (rst_in==0 at edge): head=tail=count=0, state IDLE; all outputs 0; lbuffer_full_out=0.
- Queue: circular, 2^DEPTH_LOG entries, pointers wrap modulo depth. count is DEPTH_LOG+1 bits.
- lbuffer_full_out = (count==2^DEPTH_LOG), combinational.
- Enqueue:
  - On edge with rdy_in && en_in && !full: write at tail, tail++.
  - en_in while full is ignored; entry is dropped, upstream must obey full.
- FSM states IDLE, WAIT, DRAIN.
- IDLE:
  - If count>0 && rob_lbuffer_safe_in: next edge → WAIT.
  - Register mem_en_out=1, mem_a_out=head address, mem_size_out from opcode.
- WAIT:
  - mem_en_out held high until mem_lbuffer_valid_in is seen.
  - On valid: mem_en_out←0; cdb_en_out←1; cdb_dest_out←head tag; cdb_value_out←extended data; head++; → IDLE.
  - Result is visible the cycle after valid. Earliest next issue is registered on the following edge.
- cdb_en_out is a one-cycle pulse, cleared on every edge it was not set.
- Extension rules:
  - LB: sign-extend data[7:0]. LBU: zero-extend data[7:0].
  - LH: sign-extend data[15:0]. LHU: zero-extend data[15:0].
  - LW: data unchanged.
  - Other opcode: value 0, size word (never enqueued legally).
- Simultaneous enqueue and dequeue: both take effect, count unchanged. An enqueue into an empty queue is issuable at the earliest on the next edge.
- Flush (rob_lbuffer_rst_in at edge, rdy_in high):
  - head=tail=count=0; cdb_en_out←0; mem_en_out←0.
  - Flush wins over enqueue and over a valid in the same cycle; no broadcast.
  - IDLE→IDLE. WAIT → DRAIN unless valid arrives that same cycle, in which case → IDLE.
- DRAIN: no issue; the next mem_lbuffer_valid_in is discarded, then → IDLE. New enqueues during DRAIN are accepted.
- rdy_in low: no register changes, including the cdb pulse and FSM.
- No address alignment check; the memory controller handles misaligned access.

Test Plan:
- Reset, then enqueue LW a=0x100 dest=3 with safe=1; memory returns 0x12345678 two cycles after request → mem_a_out=0x100, size=2; one cdb pulse dest=3 value=0x12345678; queue empty after.
- LB with data 0x000000F0 → value 0xFFFFFFF0. LBU same data → 0x000000F0. LH with data 0x00008001 → 0xFFFF8001. LHU with data 0x00008001 → 0x00008001.
- Enqueue 8 loads with safe=0 → full_out=1; a 9th enqueue is ignored. Raise safe → 8 broadcasts in FIFO order; tags match enqueue order across pointer wrap.
- Head enqueued, safe held 0 for 5 cycles → mem_en_out stays 0 and lbuffer_rob_h_out equals the head tag. Raise safe → request on the next edge.
- Flush in WAIT, valid arrives 3 cycles later → no cdb pulse, queue empty. A load enqueued during DRAIN issues only after the discarded valid.
- rdy_in low for 4 cycles mid-WAIT with no valid → all outputs frozen. rst_in low mid-WAIT → all outputs 0 and state IDLE on the next edge.
